// File: rtl/pe_mac_unit.sv
// rtl/pe_mac_unit.sv - systolic MAC processing element with operand forwarding, clear/drain and overflow flag
// Define PE_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module pe_mac_unit #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20,
   parameter int CNT_W  = 8,
   parameter int SIGNED = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              in_valid,
   input  logic              acc_clear,
   input  logic              drain,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              valid_out,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   output logic [CNT_W-1:0]  cnt_out,
   output logic              ovf_out
);

   localparam int   PW  = 2 * DATA_W;
   localparam logic SGN = (SIGNED != 0);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   state_t state;

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic [PW-1:0]    a_ext, b_ext, prod;
   logic [ACC_W-1:0] prod_ext, base, sum, acc_next;
   logic [ACC_W:0]   sum_w;
   logic [CNT_W-1:0] cnt_base, cnt_next;
   logic             ovf_base, ovf_next, add_ovf;

   // Extending both operands to full product width keeps the low PW bits exact for either signedness.
   assign a_ext = {{(PW-DATA_W){a_in[DATA_W-1] & SGN}}, a_in};
   assign b_ext = {{(PW-DATA_W){b_in[DATA_W-1] & SGN}}, b_in};
   assign prod  = a_ext * b_ext;

   generate
      if (ACC_W > PW) begin : g_ext
         assign prod_ext = {{(ACC_W-PW){prod[PW-1] & SGN}}, prod};
      end else begin : g_noext
         assign prod_ext = prod;
      end
   endgenerate

   assign base     = acc_clear ? '0 : acc;
   assign cnt_base = acc_clear ? '0 : cnt;
   assign ovf_base = acc_clear ? 1'b0 : ovf;

   assign sum_w = {1'b0, base} + {1'b0, prod_ext};
   assign sum   = sum_w[ACC_W-1:0];

   always_comb begin
      add_ovf = 1'b0;
      if (in_valid) begin
         if (SGN)
            add_ovf = (base[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
         else
            add_ovf = sum_w[ACC_W];
      end
   end

`ifdef PE_SAT_EN
   logic [ACC_W-1:0] sat_val;
   // Signed overflow direction follows the common sign of the two addends.
   assign sat_val = !SGN          ? {ACC_W{1'b1}} :
                    base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};
   assign acc_next = !in_valid ? base : (add_ovf ? sat_val : sum);
`else
   assign acc_next = in_valid ? sum : base;
`endif

   assign cnt_next = cnt_base + CNT_W'(in_valid && !(&cnt_base));
   assign ovf_next = ovf_base | add_ovf;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_out     <= '0;
         b_out     <= '0;
         valid_out <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         acc_out   <= '0;
         cnt_out   <= '0;
         ovf_out   <= 1'b0;
      end else begin
         a_out     <= a_in;
         b_out     <= b_in;
         valid_out <= in_valid;
         if (drain) begin
            acc_out <= acc_next;
            cnt_out <= cnt_next;
            ovf_out <= ovf_next;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
         end else begin
            acc     <= acc_next;
            cnt     <= cnt_next;
            ovf     <= ovf_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         acc_valid <= 1'b0;
      end else if (drain) begin
         state     <= DONE;
         acc_valid <= 1'b1;
      end else begin
         acc_valid <= 1'b0;
         case (state)
            IDLE:    if (in_valid) state <= ACC;
            ACC:     if (acc_clear && !in_valid) state <= IDLE;
            DONE:    state <= in_valid ? ACC : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
